baud_rate_gen: RTL and testbench

//  - Free-running tick generator for the UART: divides i_clk by NCYCLES_PER_TICK.
//  - o_tick is a one-cycle strobe, once every NCYCLES_PER_TICK clocks.
//  - Feeds the UART rx/tx oversampling logic (16x baud).
//  - Default 163 @ 50 MHz gives ~19200 baud x16.

---
 rtl/baud_rate_gen.sv | 95 +++++++++
 tb/tb_baud_rate_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/baud_rate_gen.sv
// ---------------------------------------------------------------------------
// baud_rate_gen
//
// Free-running tick generator for the UART oversampling logic. Divides i_clk
// by NCYCLES_PER_TICK and emits a one-clock strobe on o_tick once per period.
// The default of 163 at 50 MHz gives roughly 19200 baud x16.
//
// Parameters
//   NCYCLES_PER_TICK : clock cycles per tick period, legal range >= 2
//
// Ports
//   i_clk    : system clock, all logic on the rising edge
//   i_reset  : synchronous, active-high reset (counter restarts from 0)
//   i_enable : (only with BAUD_RATE_GEN_ENABLE_EN) 0 freezes the counter
//              and forces o_tick low; reset still wins over it
//   o_tick   : tick strobe, high for exactly one clock per period
//
// Configuration macro
//   BAUD_RATE_GEN_ENABLE_EN : when defined, adds the i_enable port after
//                             i_reset. When undefined the counter free-runs.
//
// o_tick is decoded combinationally from the counter register so the first
// tick lands exactly N-1 edges after reset release with no extra latency.
// ---------------------------------------------------------------------------
module baud_rate_gen #(
  parameter int NCYCLES_PER_TICK = 163
) (
  input  logic i_clk,
  input  logic i_reset,
`ifdef BAUD_RATE_GEN_ENABLE_EN
  input  logic i_enable,
`endif
  output logic o_tick
);

  // Width guard only matters for illegal values, which are rejected below.
  localparam int CNT_W = (NCYCLES_PER_TICK < 2) ? 1 : $clog2(NCYCLES_PER_TICK);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NCYCLES_PER_TICK - 1);

  generate
    if (NCYCLES_PER_TICK < 2) begin : g_bad_divider
      $error("baud_rate_gen: NCYCLES_PER_TICK must be >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             en_s;
  logic             at_max_s;

`ifdef BAUD_RATE_GEN_ENABLE_EN
  assign en_s = i_enable;
`else
  assign en_s = 1'b1;
`endif

  assign at_max_s = (cnt_q == CNT_MAX);

  // Next-count logic: wrap at the terminal count, hold while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (en_s) begin
      if (at_max_s) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register; reset has priority over wrap and enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick decode straight off the register; gated low while disabled.
  always_comb begin
    o_tick = 1'b0;
    if (en_s) begin
      o_tick = at_max_s;
    end else begin
      o_tick = 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen. Two instances (N=163 and N=2) share
// clock, reset and enable. The reference model counts post-release edges K
// and expects a tick exactly when K mod N == N-1.
module tb_baud_rate_gen;

  localparam int N_BIG   = 163;
  localparam int N_SMALL = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic tick_big;
  logic tick_small;

  int n_checks = 0;
  int n_fail   = 0;
  // Count of enabled posedges since the last reset edge.
  longint k_edges = 0;

  always #10 clk = ~clk;

  baud_rate_gen #(.NCYCLES_PER_TICK(N_BIG)) dut_big (
    .i_clk    (clk),
    .i_reset  (reset),
`ifdef BAUD_RATE_GEN_ENABLE_EN
    .i_enable (enable),
`endif
    .o_tick   (tick_big)
  );

  baud_rate_gen #(.NCYCLES_PER_TICK(N_SMALL)) dut_small (
    .i_clk    (clk),
    .i_reset  (reset),
`ifdef BAUD_RATE_GEN_ENABLE_EN
    .i_enable (enable),
`endif
    .o_tick   (tick_small)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, obs, exp, k_edges, $time);
    end
  endtask

  function automatic logic exp_tick(input int n);
    logic en_eff;
`ifdef BAUD_RATE_GEN_ENABLE_EN
    en_eff = enable;
`else
    en_eff = 1'b1;
`endif
    return en_eff && ((k_edges % n) == longint'(n - 1));
  endfunction

  // Apply inputs for one posedge, update the model, check at the negedge.
  task automatic cycle(input logic rst, input logic en, input string tag);
    reset  = rst;
    enable = en;
    @(posedge clk);
    if (rst) begin
      k_edges = 0;
    end else if (en) begin
      k_edges = k_edges + 1;
    end
    @(negedge clk);
    check_eq({tag, "_big"},   {31'd0, tick_big},   {31'd0, exp_tick(N_BIG)});
    check_eq({tag, "_small"}, {31'd0, tick_small}, {31'd0, exp_tick(N_SMALL)});
  endtask

  initial begin
    @(negedge clk);

    // Reset held for 5 cycles: no ticks.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, "reset");
      check_eq("reset_tick0", {31'd0, tick_big}, 32'd0);
    end

    // First tick and 20 full periods.
    for (int i = 0; i < 162 + 20 * N_BIG + 1; i++) begin
      cycle(1'b0, 1'b1, "period");
      if (k_edges == 162) check_eq("first_tick", {31'd0, tick_big}, 32'd1);
      if (k_edges == 163) check_eq("after_first", {31'd0, tick_big}, 32'd0);
    end

    // Run to the tick state, then reset on that edge.
    while ((k_edges % N_BIG) != 162) cycle(1'b0, 1'b1, "to_tick");
    check_eq("pre_reset_tick", {31'd0, tick_big}, 32'd1);
    cycle(1'b1, 1'b1, "reset_in_tick");
    check_eq("tick_dropped", {31'd0, tick_big}, 32'd0);
    for (int i = 0; i < 170; i++) begin
      cycle(1'b0, 1'b1, "post_reset");
      if (i == 161) check_eq("retick_162", {31'd0, tick_big}, 32'd1);
    end

`ifdef BAUD_RATE_GEN_ENABLE_EN
    // Freeze at count 100 for 50 cycles: tick delayed by exactly 50.
    cycle(1'b1, 1'b1, "en_reset");
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, "en_pre");
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'b0, "en_hold");
      check_eq("en_hold_tick0", {31'd0, tick_big}, 32'd0);
    end
    for (int i = 0; i < 70; i++) begin
      cycle(1'b0, 1'b1, "en_post");
      if (i == 61) check_eq("en_delayed_tick", {31'd0, tick_big}, 32'd1);
    end
`endif

    // Randomized reset (and enable) traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic e;
      r = ($urandom_range(0, 199) == 0);
      e = 1'b1;
`ifdef BAUD_RATE_GEN_ENABLE_EN
      e = ($urandom_range(0, 7) != 0);
`endif
      cycle(r, e, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
